ocm_table_writer: RTL and testbench
===================================

// Module: ocm_table_writer
// PURPOSE
//  Writer/sequencer side of the OCM coefficient interface. Packs an incoming byte
//  stream (UART/NIOS) into 64-bit words and writes the noise and channel tables
//  into OCM port 2. It then drives the read-side handshake that the noise and
//  channel loaders consume: load_mem, location, and the port-2 address. Asserts
//  run_en once both loaders report done_wait, gating PRBS/TX start.
// PARAMETERS
//  ADDR_W      14      OCM port-2 address width
//  ADDR_STEP   4       address increment per 64-bit word
//  NOISE_BASE  'h000   first address of noise table
//  NOISE_WORDS 128     noise table length in words (last addr 'h1fc)
//  CHAN_BASE   'h200   first address of channel table
//  CHAN_WORDS  5       channel table length in words (last addr 'h210)
//  RD_LAT      1       OCM read latency, addr2 -> mem_data, in cycles
//  TIMEOUT     1024    max cycles in a LOAD state before ERR
// PORTS
//  clk            in   1       clock
//  rstn           in   1       synchronous active-low reset
//  byte_in        in   8       table byte stream
//  byte_in_valid  in   1       byte_in qualifier
//  byte_in_ready  out  1       byte accepted when valid&ready
//  start_load     in   1       1-cycle pulse: begin loader sequence
//  addr2          out  ADDR_W  OCM port-2 address
//  wen2           out  1       OCM port-2 write strobe
//  writedata2     out  64      OCM port-2 write data
//  load_mem_n     out  1       noise loader request
//  done_wait_n    in   1       noise loader finished (level)
//  location_n     out  8       index of word currently on mem_data (noise)
//  load_mem_c     out  1       channel loader request
//  done_wait_c    in   1       channel loader finished (level)
//  location_c     out  8       index of word currently on mem_data (channel)
//  tables_written out  1       all NOISE_WORDS+CHAN_WORDS words written
//  run_en         out  1       datapath enable, sticky until reset
//  error          out  1       loader timeout, sticky until reset
// BEHAVIOUR
//  Reset (rstn=0 at posedge, any state): state=FILL. All outputs 0, with
//   byte_in_ready=1 from the first cycle after reset. Byte and word counters clear.
//  FILL: byte k of a word goes to writedata2[8k+7:8k] (little-endian, k=0..7).
//   - On the 8th accepted byte, the next cycle sets wen2=1 for exactly 1 cycle.
//     addr2 = NOISE_BASE+i*ADDR_STEP for words i<NOISE_WORDS, else
//     CHAN_BASE+(i-NOISE_WORDS)*ADDR_STEP.
//   - byte_in_ready=0 during the wen2 cycle, so an 8-byte word occupies 9 cycles min.
//   - After the last word's wen2: state READY, tables_written=1, byte_in_ready=0.
//  READY: wait for start_load. A start_load pulse in any other state is ignored.
//  LOAD_N: entered on the cycle after start_load.
//   - load_mem_n=1; addr2 starts at NOISE_BASE and advances by ADDR_STEP each cycle.
//     It saturates at the last noise address.
//   - location_n=0 for the first RD_LAT cycles, then increments by 1 per cycle.
//     It saturates at NOISE_WORDS-1.
//   - On done_wait_n=1: load_mem_n<=0, state LOAD_C.
//  LOAD_C: same as LOAD_N with CHAN_BASE, CHAN_WORDS, location_c and load_mem_c.
//   - On done_wait_c=1: load_mem_c<=0, state RUN.
//  RUN: run_en=1 and addr2 holds. Exit only by reset.
//  ERR: entered when a LOAD state lasts TIMEOUT cycles without done_wait.
//   - Sets error=1 and clears load_mem_n/load_mem_c. Exit only by reset.
//  wen2=0 in every state except the FILL write cycle. addr2 is never driven
//   past a table's last address.
//  done_wait asserted on the same cycle as load_mem rises is honoured
//   (minimum LOAD state length 1 cycle).
//  byte_in_valid while byte_in_ready=0: byte is not consumed. The source must hold it.
// TESTING
//  1. Reset, stream 1064 bytes 0x00..0xFF repeating -> 133 wen2 pulses;
//     word0 = 64'h0706050403020100 @'h000; word128 @'h200; tables_written=1.
//  2. Loader model asserts done_wait_n 130 cycles after load_mem_n ->
//     addr2 stops at 'h1fc, location_n stops at 127, then LOAD_C starts the next cycle.
//  3. done_wait_c 8 cycles after load_mem_c -> addr2 'h200..'h210 then held,
//     location_c = 0,0,1,2,3,4,4.., run_en=1 on the cycle after done_wait_c.
//  4. Loader model never asserts done_wait_n -> after 1024 cycles error=1,
//     load_mem_n=0, run_en stays 0.
//  5. start_load during FILL, with byte_in_valid gaps -> ignored; packing is unaffected by gaps.
//  6. rstn=0 mid-LOAD_C -> next cycle all outputs 0, byte_in_ready=1, refill works.

Source files
------------

// File: rtl/ocm_table_writer.sv
// ocm_table_writer
// Packs a byte stream into 64-bit words and writes the noise and channel
// coefficient tables into OCM port 2. Once both tables are written, a
// start_load pulse makes it walk port 2 for the noise loader and then the
// channel loader. run_en is raised after both loaders report done_wait.
// A loader that never finishes drives the block into a sticky error state.
module ocm_table_writer #(
    parameter int ADDR_W      = 14,
    parameter int ADDR_STEP   = 4,
    parameter int NOISE_BASE  = 'h000,
    parameter int NOISE_WORDS = 128,
    parameter int CHAN_BASE   = 'h200,
    parameter int CHAN_WORDS  = 5,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        i_byte_in,
    input  logic              i_byte_in_valid,
    output logic              o_byte_in_ready,
    input  logic              i_start_load,
    output logic [ADDR_W-1:0] o_addr2,
    output logic              o_wen2,
    output logic [63:0]       o_writedata2,
    output logic              o_load_mem_n,
    input  logic              i_done_wait_n,
    output logic [7:0]        o_location_n,
    output logic              o_load_mem_c,
    input  logic              i_done_wait_c,
    output logic [7:0]        o_location_c,
    output logic              o_tables_written,
    output logic              o_run_en,
    output logic              o_error
);

    localparam int TOTAL_WORDS = NOISE_WORDS + CHAN_WORDS;
    localparam int WCNT_W      = $clog2(TOTAL_WORDS + 1);
    localparam int TMR_W       = $clog2(TIMEOUT + 1);
    localparam int LAT_W       = $clog2(RD_LAT + 2);

    localparam logic [ADDR_W-1:0] N_FIRST = ADDR_W'(NOISE_BASE);
    localparam logic [ADDR_W-1:0] N_LAST  = ADDR_W'(NOISE_BASE + (NOISE_WORDS - 1) * ADDR_STEP);
    localparam logic [ADDR_W-1:0] C_FIRST = ADDR_W'(CHAN_BASE);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(CHAN_BASE + (CHAN_WORDS - 1) * ADDR_STEP);
    localparam logic [7:0]        N_LOC_LAST = 8'(NOISE_WORDS - 1);
    localparam logic [7:0]        C_LOC_LAST = 8'(CHAN_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0]  LAT_CYCLES = LAT_W'(RD_LAT);

    typedef enum logic [2:0] {
        S_FILL,
        S_READY,
        S_LOAD_N,
        S_LOAD_C,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [2:0]          r_byte_cnt;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [TMR_W-1:0]    r_tmr;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_byte_in_ready;
    logic [ADDR_W-1:0]   r_addr2;
    logic                r_wen2;
    logic [63:0]         r_writedata2;
    logic                r_load_mem_n;
    logic [7:0]          r_location_n;
    logic                r_load_mem_c;
    logic [7:0]          r_location_c;
    logic                r_tables_written;
    logic                r_run_en;
    logic                r_error;

    logic                w_accept;
    logic [7:0]          w_lane_we;
    logic [ADDR_W-1:0]   w_fill_addr;

    // Address advance used while a loader is being fed; never passes the table end.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [ADDR_W-1:0] last);
        step_addr = (a >= last) ? last : a + ADDR_W'(ADDR_STEP);
    endfunction

    // Word index advance for location_n/location_c, saturating at the last word.
    function automatic logic [7:0] step_loc(input logic [7:0] l, input logic [7:0] last);
        step_loc = (l >= last) ? last : l + 8'd1;
    endfunction

    assign w_accept = (r_state == S_FILL) && i_byte_in_valid && r_byte_in_ready;

    // One write enable per byte lane of the word being assembled.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign w_lane_we[gi] = w_accept && (r_byte_cnt == 3'(gi));
        end
    endgenerate

    // Table address of the word currently being filled.
    always_comb begin
        w_fill_addr = N_FIRST;
        if (int'(r_word_cnt) < NOISE_WORDS) begin
            w_fill_addr = ADDR_W'(NOISE_BASE + int'(r_word_cnt) * ADDR_STEP);
        end else begin
            w_fill_addr = ADDR_W'(CHAN_BASE + (int'(r_word_cnt) - NOISE_WORDS) * ADDR_STEP);
        end
    end

    // Little-endian byte packing into the port-2 write data register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_writedata2 <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_lane_we[k]) begin
                    r_writedata2[8*k +: 8] <= i_byte_in;
                end
            end
        end
    end

    // Main sequencer: fill, wait for start, feed both loaders, then run or error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state          <= S_FILL;
            r_byte_cnt       <= '0;
            r_word_cnt       <= '0;
            r_tmr            <= '0;
            r_lat_cnt        <= '0;
            r_byte_in_ready  <= 1'b1;
            r_addr2          <= '0;
            r_wen2           <= 1'b0;
            r_load_mem_n     <= 1'b0;
            r_location_n     <= '0;
            r_load_mem_c     <= 1'b0;
            r_location_c     <= '0;
            r_tables_written <= 1'b0;
            r_run_en         <= 1'b0;
            r_error          <= 1'b0;
        end else begin
            r_wen2 <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (r_wen2) begin
                        // Write cycle just finished: reopen the byte port or stop.
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (int'(r_word_cnt) == TOTAL_WORDS - 1) begin
                            r_state          <= S_READY;
                            r_tables_written <= 1'b1;
                            r_byte_in_ready  <= 1'b0;
                        end else begin
                            r_byte_in_ready  <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        if (r_byte_cnt == 3'd7) begin
                            r_wen2          <= 1'b1;
                            r_addr2         <= w_fill_addr;
                            r_byte_in_ready <= 1'b0;
                        end
                    end
                end
                S_READY: begin
                    if (i_start_load) begin
                        r_state      <= S_LOAD_N;
                        r_load_mem_n <= 1'b1;
                        r_addr2      <= N_FIRST;
                        r_location_n <= '0;
                        r_lat_cnt    <= '0;
                        r_tmr        <= '0;
                    end
                end
                S_LOAD_N: begin
                    if (i_done_wait_n) begin
                        r_state      <= S_LOAD_C;
                        r_load_mem_n <= 1'b0;
                        r_load_mem_c <= 1'b1;
                        r_addr2      <= C_FIRST;
                        r_location_c <= '0;
                        r_lat_cnt    <= '0;
                        r_tmr        <= '0;
                    end else if (r_tmr == TMR_LAST) begin
                        r_state      <= S_ERR;
                        r_error      <= 1'b1;
                        r_load_mem_n <= 1'b0;
                        r_load_mem_c <= 1'b0;
                    end else begin
                        r_tmr   <= r_tmr + 1'b1;
                        r_addr2 <= step_addr(r_addr2, N_LAST);
                        // location trails the address by the OCM read latency.
                        if (r_lat_cnt < LAT_CYCLES) begin
                            r_lat_cnt <= r_lat_cnt + 1'b1;
                        end else begin
                            r_location_n <= step_loc(r_location_n, N_LOC_LAST);
                        end
                    end
                end
                S_LOAD_C: begin
                    if (i_done_wait_c) begin
                        r_state      <= S_RUN;
                        r_load_mem_c <= 1'b0;
                        r_run_en     <= 1'b1;
                    end else if (r_tmr == TMR_LAST) begin
                        r_state      <= S_ERR;
                        r_error      <= 1'b1;
                        r_load_mem_n <= 1'b0;
                        r_load_mem_c <= 1'b0;
                    end else begin
                        r_tmr   <= r_tmr + 1'b1;
                        r_addr2 <= step_addr(r_addr2, C_LAST);
                        if (r_lat_cnt < LAT_CYCLES) begin
                            r_lat_cnt <= r_lat_cnt + 1'b1;
                        end else begin
                            r_location_c <= step_loc(r_location_c, C_LOC_LAST);
                        end
                    end
                end
                S_RUN: begin
                    r_run_en <= 1'b1;
                end
                S_ERR: begin
                    r_error      <= 1'b1;
                    r_load_mem_n <= 1'b0;
                    r_load_mem_c <= 1'b0;
                end
                default: begin
                    r_state      <= S_ERR;
                    r_error      <= 1'b1;
                    r_load_mem_n <= 1'b0;
                    r_load_mem_c <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_in_ready  = r_byte_in_ready;
    assign o_addr2          = r_addr2;
    assign o_wen2           = r_wen2;
    assign o_writedata2     = r_writedata2;
    assign o_load_mem_n     = r_load_mem_n;
    assign o_location_n     = r_location_n;
    assign o_load_mem_c     = r_load_mem_c;
    assign o_location_c     = r_location_c;
    assign o_tables_written = r_tables_written;
    assign o_run_en         = r_run_en;
    assign o_error          = r_error;

endmodule

// File: tb/tb_ocm_table_writer.sv
// tb_ocm_table_writer
// Scoreboard bench: stimulus pushes expected port-2 writes and expected
// per-cycle loader addresses/locations into queues; a negedge monitor pops
// and compares whenever wen2, load_mem_n or load_mem_c is presented.
module tb_ocm_table_writer;

    localparam int ADDR_W = 14;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } wr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        loc;
    } ld_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [7:0]        i_byte_in;
    logic              i_byte_in_valid;
    logic              o_byte_in_ready;
    logic              i_start_load;
    logic [ADDR_W-1:0] o_addr2;
    logic              o_wen2;
    logic [63:0]       o_writedata2;
    logic              o_load_mem_n;
    logic              i_done_wait_n;
    logic [7:0]        o_location_n;
    logic              o_load_mem_c;
    logic              i_done_wait_c;
    logic [7:0]        o_location_c;
    logic              o_tables_written;
    logic              o_run_en;
    logic              o_error;

    wr_t q_wr[$];
    ld_t q_ln[$];
    ld_t q_lc[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    ocm_table_writer dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_byte_in        (i_byte_in),
        .i_byte_in_valid  (i_byte_in_valid),
        .o_byte_in_ready  (o_byte_in_ready),
        .i_start_load     (i_start_load),
        .o_addr2          (o_addr2),
        .o_wen2           (o_wen2),
        .o_writedata2     (o_writedata2),
        .o_load_mem_n     (o_load_mem_n),
        .i_done_wait_n    (i_done_wait_n),
        .o_location_n     (o_location_n),
        .o_load_mem_c     (o_load_mem_c),
        .i_done_wait_c    (i_done_wait_c),
        .o_location_c     (o_location_c),
        .o_tables_written (o_tables_written),
        .o_run_en         (o_run_en),
        .o_error          (o_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Stream byte j of fill pass 'mode'.
    function automatic logic [7:0] pat(input int mode, input int j);
        case (mode)
            0:       pat = 8'(j);
            1:       pat = 8'(j * 3 + 1);
            default: pat = 8'(j) ^ 8'h5a;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int i);
        exp_addr = (i < 128) ? ADDR_W'(i * 4) : ADDR_W'('h200 + (i - 128) * 4);
    endfunction

    // Expected loader walk: addr saturates at the last word, location lags by one.
    task automatic push_load(input bit chan, input int cycles);
        int  words;
        int  base;
        int  a;
        int  l;
        words = chan ? 5 : 128;
        base  = chan ? 'h200 : 'h000;
        for (int t = 0; t < cycles; t++) begin
            a = (t < words - 1) ? t : words - 1;
            l = (t == 0) ? 0 : ((t - 1 < words - 1) ? t - 1 : words - 1);
            if (chan) q_lc.push_back('{addr: ADDR_W'(base + a * 4), loc: 8'(l)});
            else      q_ln.push_back('{addr: ADDR_W'(base + a * 4), loc: 8'(l)});
        end
    endtask

    // Present one byte and hold it until a cycle with ready=1 consumes it.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        i_byte_in       = b;
        i_byte_in_valid = 1'b1;
        for (int n = 0; n < 32 && !done; n++) begin
            done = o_byte_in_ready;
            @(posedge clk); #1;
        end
        if (!done) check("byte_handshake_timeout", 64'd0, 64'd1);
        i_byte_in_valid = 1'b0;
    endtask

    task automatic start_pulse();
        i_start_load = 1'b1;
        @(posedge clk); #1;
        i_start_load = 1'b0;
    endtask

    task automatic fill_tables(input int mode, input bit gaps, input int pulse_at);
        logic [63:0] d;
        for (int i = 0; i < 133; i++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = pat(mode, i * 8 + k);
            q_wr.push_back('{addr: exp_addr(i), data: d});
            for (int k = 0; k < 8; k++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                end
                if (i * 8 + k == pulse_at) start_pulse();
                send_byte(d[8*k +: 8]);
            end
        end
        // Now in the last word's write cycle.
        check("tw_during_last_wen", o_tables_written, 64'd0);
        check("ready_during_last_wen", o_byte_in_ready, 64'd0);
        @(posedge clk); #1;
        check("tables_written", o_tables_written, 64'd1);
        check("ready_after_fill", o_byte_in_ready, 64'd0);
        check("wen_after_fill", o_wen2, 64'd0);
        check("wr_queue_drained", 64'(q_wr.size()), 64'd0);
        $display("fill pass %0d complete, %0d writes so far", mode, n_writes);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   o_byte_in_ready, 64'd1);
        check({tag, "_wen2"},    o_wen2, 64'd0);
        check({tag, "_addr2"},   64'(o_addr2), 64'd0);
        check({tag, "_wdata"},   o_writedata2, 64'd0);
        check({tag, "_ldn"},     o_load_mem_n, 64'd0);
        check({tag, "_ldc"},     o_load_mem_c, 64'd0);
        check({tag, "_locn"},    64'(o_location_n), 64'd0);
        check({tag, "_locc"},    64'(o_location_c), 64'd0);
        check({tag, "_tw"},      o_tables_written, 64'd0);
        check({tag, "_run"},     o_run_en, 64'd0);
        check({tag, "_err"},     o_error, 64'd0);
    endtask

    // Monitor: compare every presented write / loader cycle against the queues.
    always @(negedge clk) begin
        wr_t w;
        ld_t l;
        if (o_wen2) begin
            if (q_wr.size() == 0) begin
                check("wr_unexpected", 64'd1, 64'd0);
            end else begin
                w = q_wr.pop_front();
                n_writes++;
                check("wr_addr", 64'(o_addr2), 64'(w.addr));
                check("wr_data", o_writedata2, w.data);
                check("wr_ready_low", o_byte_in_ready, 64'd0);
                $display("write %0d addr=%h data=%h", n_writes, o_addr2, o_writedata2);
            end
        end
        if (o_load_mem_n) begin
            if (q_ln.size() == 0) begin
                check("load_n_unexpected", 64'd1, 64'd0);
            end else begin
                l = q_ln.pop_front();
                check("load_n_addr", 64'(o_addr2), 64'(l.addr));
                check("load_n_loc", 64'(o_location_n), 64'(l.loc));
            end
        end
        if (o_load_mem_c) begin
            if (q_lc.size() == 0) begin
                check("load_c_unexpected", 64'd1, 64'd0);
            end else begin
                l = q_lc.pop_front();
                check("load_c_addr", 64'(o_addr2), 64'(l.addr));
                check("load_c_loc", 64'(o_location_c), 64'(l.loc));
            end
        end
    end

    initial begin
        rstn            = 1'b0;
        i_byte_in       = 8'h00;
        i_byte_in_valid = 1'b0;
        i_start_load    = 1'b0;
        i_done_wait_n   = 1'b0;
        i_done_wait_c   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Fill with gaps and a stray start_load while filling.
        fill_tables(0, 1'b1, 100);

        // Noise loader finishes 130 cycles after load_mem_n rises.
        push_load(1'b0, 131);
        start_pulse();
        $display("LOAD_N started");
        repeat (130) begin @(posedge clk); #1; end
        check("ldn_addr_sat", 64'(o_addr2), 64'h1fc);
        check("ldn_loc_sat", 64'(o_location_n), 64'd127);
        i_done_wait_n = 1'b1;
        push_load(1'b1, 9);
        @(posedge clk); #1;
        check("ldc_start_ldn", o_load_mem_n, 64'd0);
        check("ldc_start_ldc", o_load_mem_c, 64'd1);
        check("ldc_start_addr", 64'(o_addr2), 64'h200);
        repeat (8) begin @(posedge clk); #1; end
        check("run_before_done", o_run_en, 64'd0);
        i_done_wait_c = 1'b1;
        @(posedge clk); #1;
        check("run_en", o_run_en, 64'd1);
        check("run_ldc_low", o_load_mem_c, 64'd0);
        check("run_addr_hold", 64'(o_addr2), 64'h210);
        $display("RUN reached");
        start_pulse();
        repeat (3) begin @(posedge clk); #1; end
        check("run_sticky", o_run_en, 64'd1);
        check("run_addr_hold2", 64'(o_addr2), 64'h210);
        check("run_err_low", o_error, 64'd0);
        check("ln_queue_drained", 64'(q_ln.size()), 64'd0);
        check("lc_queue_drained", 64'(q_lc.size()), 64'd0);

        // Reset from RUN, refill, then reset in the middle of LOAD_C.
        rstn = 1'b0; i_done_wait_n = 1'b0; i_done_wait_c = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        fill_tables(1, 1'b0, -1);
        push_load(1'b0, 1);
        start_pulse();
        i_done_wait_n = 1'b1;   // same cycle as load_mem_n rises
        push_load(1'b1, 3);
        @(posedge clk); #1;
        check("min_len_ldc", o_load_mem_c, 64'd1);
        check("min_len_addr", 64'(o_addr2), 64'h200);
        i_done_wait_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rstn = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midload_reset");
        rstn = 1'b1;
        check("lc_queue_after_reset", 64'(q_lc.size()), 64'd0);
        $display("reset during LOAD_C done");

        // Refill after reset, then let the noise loader time out.
        fill_tables(2, 1'b1, -1);
        push_load(1'b0, 1024);
        start_pulse();
        repeat (1023) begin @(posedge clk); #1; end
        check("to_err_before", o_error, 64'd0);
        check("to_ldn_before", o_load_mem_n, 64'd1);
        check("to_addr_sat", 64'(o_addr2), 64'h1fc);
        @(posedge clk); #1;
        check("to_err", o_error, 64'd1);
        check("to_ldn_low", o_load_mem_n, 64'd0);
        check("to_ldc_low", o_load_mem_c, 64'd0);
        check("to_run_low", o_run_en, 64'd0);
        start_pulse();
        repeat (5) begin @(posedge clk); #1; end
        check("to_err_sticky", o_error, 64'd1);
        check("to_run_stays_low", o_run_en, 64'd0);
        $display("timeout reached ERR");

        check("final_wr_queue", 64'(q_wr.size()), 64'd0);
        check("final_ln_queue", 64'(q_ln.size()), 64'd0);
        check("final_lc_queue", 64'(q_lc.size()), 64'd0);
        check("total_writes", 64'(n_writes), 64'd399);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
